// File: rtl/bt_pkg.sv
// Shared types and width helpers for the decision-tree branch stage.
// Ports: none (package).
// Node word layout, low to high: fidx[IDX_W], thr[FEAT_W], leaf.
package bt_pkg;

    localparam int NUM_FEAT_DFLT = 4;
    localparam int FEAT_W_DFLT   = 8;

    // A single-feature tree still carries a one-bit index field.
    function automatic int idxWidth(input int numFeat);
        return (numFeat > 1) ? $clog2(numFeat) : 1;
    endfunction

    function automatic int memWidth(input int numFeat, input int featW);
        return 1 + featW + idxWidth(numFeat);
    endfunction

    localparam int IDX_W = idxWidth(NUM_FEAT_DFLT);
    localparam int MEM_W = memWidth(NUM_FEAT_DFLT, FEAT_W_DFLT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        ROUTE
    } branch_state_e;

    typedef enum logic [1:0] {
        R_BOT,
        R_RIGHT,
        R_LEAF
    } route_e;

endpackage

// File: rtl/bt_sync_fifo.sv
// Single-clock FIFO holding queued (sample, node) pairs for the branch stage.
// Latency: a pushed entry is visible on rdData the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk, rst (sync, active-high); push/wrData write side; pop/rdData read side
//        (rdData shows the head entry, valid while !empty); full, empty status.
module bt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wrData,
    input  logic             pop,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // The extra top bit separates "same slot, wrapped" (full) from "same slot" (empty).
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) begin
                wrPtr <= wrPtr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rdPtr <= rdPtr + (AW+1)'(1);
            end
        end
    end

    // Storage is left unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr[AW-1:0]] <= wrData;
        end
    end

endmodule

// File: rtl/branch_stage_pipe.sv
// Decision-tree internal node stage: fetch node word, compare feature, route to bottom/right/leaf.
// Latency: in_valid accepted in cycle N, popped in N+1, mem_req_valid in N+2; route after the response.
// Backpressure: in_ready drops when the input FIFO is full; a routed pair holds until its output's ready.
// Ports: clk, rst (sync, active-high); in_* input pairs; mem_req_* node fetch; mem_rsp_* node word;
//        bot_*, right_*, leaf_* output handshakes sharing out_sample/out_node/leaf_class;
//        err_fidx, err_ovf sticky error flags.
module branch_stage_pipe
    import bt_pkg::*;
#(
    parameter int NUM_FEAT = 4,
    parameter int FEAT_W   = 8,
    parameter int NODE_W   = 8,
    parameter int DEPTH    = 4,
    parameter int CMP_MODE = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_FEAT*FEAT_W-1:0]             in_sample,
    input  logic [NODE_W-1:0]                      in_node,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [NODE_W-1:0]                      mem_req_addr,
    input  logic                                   mem_rsp_valid,
    input  logic [memWidth(NUM_FEAT, FEAT_W)-1:0]  mem_rsp_data,
    output logic                                   bot_valid,
    input  logic                                   bot_ready,
    output logic                                   right_valid,
    input  logic                                   right_ready,
    output logic                                   leaf_valid,
    input  logic                                   leaf_ready,
    output logic [NUM_FEAT*FEAT_W-1:0]             out_sample,
    output logic [NODE_W-1:0]                      out_node,
    output logic [FEAT_W-1:0]                      leaf_class,
    output logic                                   err_fidx,
    output logic                                   err_ovf
);

    localparam int FIDX_W  = idxWidth(NUM_FEAT);
    localparam int WORD_W  = memWidth(NUM_FEAT, FEAT_W);
    localparam int SAMP_W  = NUM_FEAT * FEAT_W;
    localparam int ENTRY_W = SAMP_W + NODE_W;
    localparam logic [FIDX_W:0] NUM_FEAT_EXT = (FIDX_W+1)'(NUM_FEAT);

    branch_state_e       state;
    branch_state_e       stateNext;
    route_e              routeSel;
    route_e              routeNext;

    logic                fifoPush;
    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [ENTRY_W-1:0]  fifoHead;

    logic [SAMP_W-1:0]   workSample;
    logic [NODE_W-1:0]   workNode;
    logic [NODE_W-1:0]   outNode;
    logic [FEAT_W-1:0]   leafClass;
    logic                errFidx;
    logic                errOvf;

    logic                rspLeaf;
    logic [FEAT_W-1:0]   rspThr;
    logic [FIDX_W-1:0]   rspFidx;
    logic [FEAT_W-1:0]   feat;
    logic                fidxBad;
    logic                goBot;
    logic [NODE_W:0]     childWide;
    logic [NODE_W-1:0]   childNext;
    logic [FEAT_W-1:0]   classNext;
    logic                fidxHit;
    logic                ovfHit;
    logic                selReady;
    logic                rspTake;

    // ---------------- input queue ----------------
    assign in_ready = !fifoFull;
    assign fifoPush = in_valid && in_ready;

    bt_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) inFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifoPush),
        .wrData ({in_node, in_sample}),
        .pop    (fifoPop),
        .rdData (fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        selReady = 1'b0;
        case (routeSel)
            R_BOT:   selReady = bot_ready;
            R_RIGHT: selReady = right_ready;
            R_LEAF:  selReady = leaf_ready;
            default: selReady = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = state;
        fifoPop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    stateNext = ROUTE;
                end
            end
            ROUTE: begin
                if (selReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Responses outside WAIT are strays (e.g. for a request dropped by reset).
    assign rspTake = (state == WAIT) && mem_rsp_valid;

    // ---------------- route decision ----------------
    assign rspLeaf = mem_rsp_data[WORD_W-1];
    assign rspThr  = mem_rsp_data[FIDX_W +: FEAT_W];
    assign rspFidx = mem_rsp_data[FIDX_W-1:0];

    always_comb begin
        // Mux by explicit match so an out-of-range index never slices past the sample.
        feat = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (rspFidx == FIDX_W'(k)) begin
                feat = workSample[k*FEAT_W +: FEAT_W];
            end
        end
    end

    assign fidxBad   = ({1'b0, rspFidx} >= NUM_FEAT_EXT);
    assign goBot     = (CMP_MODE != 0) ? (feat <= rspThr) : (feat < rspThr);
    // {node, 0} is 2*node in NODE_W+1 bits; the top bit flags a child past the index range.
    assign childWide = {workNode, 1'b0} + (NODE_W+1)'(goBot ? 1 : 2);

    always_comb begin
        routeNext = R_LEAF;
        childNext = '0;
        classNext = '0;
        fidxHit   = 1'b0;
        ovfHit    = 1'b0;
        if (rspLeaf) begin
            classNext = rspThr;
        end else if (fidxBad) begin
            fidxHit = 1'b1;
        end else if (childWide[NODE_W]) begin
            ovfHit = 1'b1;
        end else begin
            routeNext = goBot ? R_BOT : R_RIGHT;
            childNext = childWide[NODE_W-1:0];
        end
    end

    // ---------------- working and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            workSample <= '0;
            workNode   <= '0;
            routeSel   <= R_BOT;
            outNode    <= '0;
            leafClass  <= '0;
            errFidx    <= 1'b0;
            errOvf     <= 1'b0;
        end else begin
            if (fifoPop) begin
                {workNode, workSample} <= fifoHead;
            end
            if (rspTake) begin
                routeSel  <= routeNext;
                outNode   <= childNext;
                leafClass <= classNext;
                if (fidxHit) begin
                    errFidx <= 1'b1;
                end
                if (ovfHit) begin
                    errOvf <= 1'b1;
                end
            end
        end
    end

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = workNode;
    assign bot_valid     = (state == ROUTE) && (routeSel == R_BOT);
    assign right_valid   = (state == ROUTE) && (routeSel == R_RIGHT);
    assign leaf_valid    = (state == ROUTE) && (routeSel == R_LEAF);
    assign out_sample    = workSample;
    assign out_node      = outNode;
    assign leaf_class    = leafClass;
    assign err_fidx      = errFidx;
    assign err_ovf       = errOvf;

endmodule

// File: tb/tb_branch_stage_pipe.sv
// Scoreboard bench for branch_stage_pipe: two instances (CMP_MODE 0 and 1) share all inputs.
// A responder returns queued node words; a monitor pops expected routes on every output handshake.
module tb_branch_stage_pipe;
    import bt_pkg::*;

    localparam int SW = 32;
    localparam int NW = 8;
    localparam int FW = 8;
    localparam int MW = bt_pkg::MEM_W;

    typedef struct {
        int            kind;    // 0 bottom, 1 right, 2 leaf
        logic [NW-1:0] node;
        logic [SW-1:0] sample;
        logic [FW-1:0] cls;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [SW-1:0] in_sample;
    logic [NW-1:0] in_node;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [MW-1:0] mem_rsp_data;
    logic          bot_ready;
    logic          right_ready;
    logic          leaf_ready;

    logic          inReady     [2];
    logic          memReqValid [2];
    logic [NW-1:0] memReqAddr  [2];
    logic          botValid    [2];
    logic          rightValid  [2];
    logic          leafValid   [2];
    logic [SW-1:0] outSample   [2];
    logic [NW-1:0] outNode     [2];
    logic [FW-1:0] leafClass   [2];
    logic          errFidx     [2];
    logic          errOvf      [2];

    exp_t          expQ0[$];
    exp_t          expQ1[$];
    logic [MW-1:0] rspQ[$];
    logic [NW-1:0] addrQ[$];
    bit            rspAuto;
    bit            strayReq;
    int            nChecks = 0;
    int            nFails  = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        branch_stage_pipe #(
            .NUM_FEAT (4),
            .FEAT_W   (FW),
            .NODE_W   (NW),
            .DEPTH    (4),
            .CMP_MODE (m)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid),
            .in_ready      (inReady[m]),
            .in_sample     (in_sample),
            .in_node       (in_node),
            .mem_req_valid (memReqValid[m]),
            .mem_req_ready (mem_req_ready),
            .mem_req_addr  (memReqAddr[m]),
            .mem_rsp_valid (mem_rsp_valid),
            .mem_rsp_data  (mem_rsp_data),
            .bot_valid     (botValid[m]),
            .bot_ready     (bot_ready),
            .right_valid   (rightValid[m]),
            .right_ready   (right_ready),
            .leaf_valid    (leafValid[m]),
            .leaf_ready    (leaf_ready),
            .out_sample    (outSample[m]),
            .out_node      (outNode[m]),
            .leaf_class    (leafClass[m]),
            .err_fidx      (errFidx[m]),
            .err_ovf       (errOvf[m])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [MW-1:0] mkRsp(input logic leaf, input logic [FW-1:0] thr,
                                            input logic [bt_pkg::IDX_W-1:0] fidx);
        return {leaf, thr, fidx};
    endfunction

    task automatic expectPair(input logic [SW-1:0] s, input logic [NW-1:0] n, input logic [MW-1:0] rsp,
                              input int k0, input logic [NW-1:0] n0,
                              input int k1, input logic [NW-1:0] n1, input logic [FW-1:0] cls);
        exp_t e;
        e.sample = s;
        e.cls    = cls;
        e.kind   = k0;
        e.node   = n0;
        expQ0.push_back(e);
        e.kind   = k1;
        e.node   = n1;
        expQ1.push_back(e);
        rspQ.push_back(rsp);
        addrQ.push_back(n);
    endtask

    // Offer one pair; returns #1 after the accepting edge, or after maxWait refused cycles.
    task automatic offer(input logic [SW-1:0] s, input logic [NW-1:0] n, input int maxWait, output bit acc);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = s;
        in_node   = n;
        acc       = 1'b0;
        for (int i = 0; i < maxWait; i++) begin
            if (inReady[0]) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            if (expQ0.size() == 0 && expQ1.size() == 0) break;
            @(negedge clk);
        end
        check({"drain_", name}, expQ0.size() + expQ1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic monitorOne(input int m);
        exp_t e;
        int   kind;
        bit   fire;
        fire = (botValid[m] && bot_ready) || (rightValid[m] && right_ready) || (leafValid[m] && leaf_ready);
        if (!fire) return;
        kind = botValid[m] ? 0 : (rightValid[m] ? 1 : 2);
        if ((m == 0 && expQ0.size() == 0) || (m == 1 && expQ1.size() == 0)) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected_output dut%0d: got route %0d, required no output", m, kind);
            return;
        end
        e = (m == 0) ? expQ0.pop_front() : expQ1.pop_front();
        check($sformatf("route_kind_dut%0d", m), kind, e.kind);
        check($sformatf("onehot_dut%0d", m), 64'(botValid[m]) + 64'(rightValid[m]) + 64'(leafValid[m]), 1);
        check($sformatf("out_node_dut%0d", m), outNode[m], e.node);
        check($sformatf("out_sample_dut%0d", m), outSample[m], e.sample);
        if (e.kind == 2) begin
            check($sformatf("leaf_class_dut%0d", m), leafClass[m], e.cls);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int m = 0; m < 2; m++) monitorOne(m);
            end
        end
    end

    // Memory responder: one response pulse the cycle after each accepted request.
    initial begin
        bit strayDone;
        strayDone     = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (strayReq && !strayDone) begin
                strayDone     = 1'b1;
                mem_rsp_data  = mkRsp(1'b1, 8'h55, 2'd0);
                mem_rsp_valid = 1'b1;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
            end else if (!rst && rspAuto && memReqValid[0] && mem_req_ready) begin
                if (addrQ.size() != 0) check("req_addr", memReqAddr[0], addrQ.pop_front());
                @(posedge clk);
                #1;
                if (rspQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_request: got addr 0x%0h, required no request", memReqAddr[0]);
                end else begin
                    mem_rsp_data  = rspQ.pop_front();
                    mem_rsp_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    mem_rsp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    localparam logic [SW-1:0] SMP = 32'h10203040;   // {f3,f2,f1,f0} = {10,20,30,40}

    initial begin
        bit            acc;
        int            lat;
        logic [NW-1:0] fillNode [5] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11};

        rst           = 1'b1;
        in_valid      = 1'b0;
        in_sample     = '0;
        in_node       = '0;
        mem_req_ready = 1'b1;
        bot_ready     = 1'b1;
        right_ready   = 1'b1;
        leaf_ready    = 1'b1;
        rspAuto       = 1'b1;
        strayReq      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_in_ready_%0d", m), inReady[m], 1);
            check($sformatf("rst_valids_%0d", m),
                  {memReqValid[m], botValid[m], rightValid[m], leafValid[m]}, 0);
            check($sformatf("rst_addr_node_cls_%0d", m), {memReqAddr[m], outNode[m], leafClass[m]}, 0);
            check($sformatf("rst_sample_%0d", m), outSample[m], 0);
            check($sformatf("rst_err_%0d", m), {errFidx[m], errOvf[m]}, 0);
        end
        rst = 1'b0;

        // 0x30 < 0x35 -> bottom, node 3; request two cycles after the push cycle
        expectPair(SMP, 8'd1, mkRsp(1'b0, 8'h35, 2'd1), 0, 8'd3, 0, 8'd3, 8'h00);
        offer(SMP, 8'd1, 4, acc);
        check("accept_first", acc, 1);
        check("no_req_in_pop_cycle", memReqValid[0], 0);
        lat = 1;
        for (int i = 0; i < 8 && !memReqValid[0]; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("req_latency", lat, 2);
        drain("bot", 50);

        // 0x30 >= 0x25 -> right, node 4, held stable while right_ready is low
        right_ready = 1'b0;
        expectPair(SMP, 8'd1, mkRsp(1'b0, 8'h25, 2'd1), 1, 8'd4, 1, 8'd4, 8'h00);
        offer(SMP, 8'd1, 4, acc);
        for (int i = 0; i < 20 && !rightValid[0]; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_right_valid", {rightValid[0], rightValid[1], botValid[0], leafValid[0]}, 4'b1100);
            check("stall_out_node", outNode[0], 4);
            check("stall_out_sample", outSample[0], SMP);
        end
        right_ready = 1'b1;
        drain("right", 50);

        // Equal feature and threshold: mode 0 right/4, mode 1 bottom/3
        expectPair(SMP, 8'd1, mkRsp(1'b0, 8'h30, 2'd1), 1, 8'd4, 0, 8'd3, 8'h00);
        offer(SMP, 8'd1, 4, acc);
        drain("equal", 50);

        // Leaf node word -> class 0x07
        expectPair(SMP, 8'd1, mkRsp(1'b1, 8'h07, 2'd0), 2, 8'd0, 2, 8'd0, 8'h07);
        offer(SMP, 8'd1, 4, acc);
        drain("leaf", 50);

        // Largest child that still fits: node 127, 0x40 < 0x41 -> bottom 255
        expectPair(SMP, 8'd127, mkRsp(1'b0, 8'h41, 2'd0), 0, 8'd255, 0, 8'd255, 8'h00);
        offer(SMP, 8'd127, 4, acc);
        drain("max_child", 50);
        check("no_ovf_yet", {errOvf[0], errOvf[1]}, 0);

        // Node 200 -> right child 402 overflows 8 bits -> leaf class 0, sticky err_ovf
        expectPair(SMP, 8'd200, mkRsp(1'b0, 8'h00, 2'd0), 2, 8'd0, 2, 8'd0, 8'h00);
        offer(SMP, 8'd200, 4, acc);
        drain("ovf", 50);
        check("err_ovf_set", {errOvf[0], errOvf[1]}, 2'b11);
        check("err_fidx_clear", {errFidx[0], errFidx[1]}, 0);

        // Requests blocked: one pair in the working registers plus four queued
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [SW-1:0] s;
            s = {8'(i + 1), 24'h203040};
            expectPair(s, NW'(i + 1), mkRsp(1'b0, 8'h35, 2'd1), 0, fillNode[i], 0, fillNode[i], 8'h00);
            offer(s, NW'(i + 1), 4, acc);
            check($sformatf("fill_accept_%0d", i), acc, 1);
        end
        offer({8'hEE, 24'h203040}, 8'd6, 3, acc);
        check("fill_reject_sixth", acc, 0);
        check("fill_in_ready_low", inReady[0], 0);
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        drain("fill", 300);

        // Reset while waiting on memory, then a stray response
        rspAuto = 1'b0;
        offer(SMP, 8'd9, 4, acc);
        for (int i = 0; i < 10 && !memReqValid[0]; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("in_wait_no_req", memReqValid[0], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        strayReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", {memReqValid[0], botValid[0], rightValid[0], leafValid[0],
                                    memReqValid[1], botValid[1], rightValid[1], leafValid[1]}, 0);
        end
        check("post_rst_in_ready", {inReady[0], inReady[1]}, 2'b11);
        check("post_rst_regs", {outNode[0], leafClass[0], memReqAddr[0], errOvf[0], errFidx[0]}, 0);
        check("post_rst_sample", outSample[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
